// File: rtl/uart_rx_frame_ctrl_if.sv
// Handshake bundle between the pad-side line/config inputs and the receive datapath strobes.
// The controller uses the master view; the serial-line and datapath side uses the slave view.
interface uart_rx_frame_ctrl_if;
    logic       en;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       frame_active;
    logic       samp_strobe;
    logic       samp_bit;
    logic [3:0] bit_idx;
    logic       frame_done;
    logic       stop_error;
    logic       start_glitch;

    modport master (
        input  en, rx_in, par_en, par_typ,
        output cfg_par_en, cfg_par_typ, frame_active, samp_strobe, samp_bit,
               bit_idx, frame_done, stop_error, start_glitch
    );

    modport slave (
        output en, rx_in, par_en, par_typ,
        input  cfg_par_en, cfg_par_typ, frame_active, samp_strobe, samp_bit,
               bit_idx, frame_done, stop_error, start_glitch
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Oversampling UART receive frame sequencer: start-bit validation, configuration latch and
// one majority-voted mid-bit strobe per data/parity/stop bit for the downstream deserializer.
module uart_rx_frame_ctrl #(
    parameter int OVS = 8,
    parameter int CW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_frame_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [CW-1:0] CAP0 = CW'(OVS/2 - 2);
    localparam logic [CW-1:0] CAP1 = CW'(OVS/2 - 1);
    localparam logic [CW-1:0] HALF = CW'(OVS/2);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    data_idx, data_idx_nxt;
    logic          sync1, rx_s, rx_hist;
    logic          samp0, samp1, maj;
    logic          latch_cfg;

    logic          cfg_par_en_q, cfg_par_typ_q, frame_active_q, strobe_q, samp_bit_q;
    logic [3:0]    bit_idx_q;
    logic          done_q, stop_err_q, glitch_q;

    logic          frame_active_nxt, strobe_nxt, samp_bit_nxt, done_nxt, stop_err_nxt, glitch_nxt;
    logic [3:0]    bit_idx_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_idx <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            data_idx <= data_idx_nxt;
        end
    end

    assign maj = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = (state == IDLE || cnt == LAST) ? '0 : cnt + CW'(1);
        data_idx_nxt     = data_idx;
        latch_cfg        = 1'b0;
        strobe_nxt       = 1'b0;
        samp_bit_nxt     = samp_bit_q;
        bit_idx_nxt      = bit_idx_q;
        done_nxt         = 1'b0;
        stop_err_nxt     = stop_err_q;
        glitch_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && !rx_s && rx_hist) begin
                    state_nxt    = START;
                    latch_cfg    = 1'b1;
                    data_idx_nxt = '0;
                end
            end
            START: begin
                if (cnt == HALF && maj) begin
                    glitch_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (cnt == HALF) begin
                    strobe_nxt   = 1'b1;
                    samp_bit_nxt = maj;
                    bit_idx_nxt  = {1'b0, data_idx};
                end
                if (cnt == LAST) begin
                    if (data_idx == 3'd7) begin
                        state_nxt = cfg_par_en_q ? PARITY : STOP;
                    end else begin
                        data_idx_nxt = data_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (cnt == HALF) begin
                    strobe_nxt   = 1'b1;
                    samp_bit_nxt = maj;
                    bit_idx_nxt  = 4'd8;
                end
                if (cnt == LAST) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Re-arm half a bit early so a back-to-back start edge is never missed.
                if (cnt == HALF) begin
                    strobe_nxt   = 1'b1;
                    samp_bit_nxt = maj;
                    bit_idx_nxt  = 4'd9;
                    done_nxt     = 1'b1;
                    stop_err_nxt = ~maj;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == IDLE) begin
            cnt_nxt = '0;
        end
        frame_active_nxt = (state_nxt != IDLE) || done_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1          <= 1'b1;
            rx_s           <= 1'b1;
            rx_hist        <= 1'b1;
            samp0          <= 1'b0;
            samp1          <= 1'b0;
            cfg_par_en_q   <= 1'b0;
            cfg_par_typ_q  <= 1'b0;
            frame_active_q <= 1'b0;
            strobe_q       <= 1'b0;
            samp_bit_q     <= 1'b0;
            bit_idx_q      <= '0;
            done_q         <= 1'b0;
            stop_err_q     <= 1'b0;
            glitch_q       <= 1'b0;
        end else begin
            sync1          <= bus.rx_in;
            rx_s           <= sync1;
            rx_hist        <= rx_s;
            if (state != IDLE && cnt == CAP0) samp0 <= rx_s;
            if (state != IDLE && cnt == CAP1) samp1 <= rx_s;
            if (latch_cfg) begin
                cfg_par_en_q  <= bus.par_en;
                cfg_par_typ_q <= bus.par_typ;
            end
            frame_active_q <= frame_active_nxt;
            strobe_q       <= strobe_nxt;
            samp_bit_q     <= samp_bit_nxt;
            bit_idx_q      <= bit_idx_nxt;
            done_q         <= done_nxt;
            stop_err_q     <= stop_err_nxt;
            glitch_q       <= glitch_nxt;
        end
    end

    assign bus.cfg_par_en   = cfg_par_en_q;
    assign bus.cfg_par_typ  = cfg_par_typ_q;
    assign bus.frame_active = frame_active_q;
    assign bus.samp_strobe  = strobe_q;
    assign bus.samp_bit     = samp_bit_q;
    assign bus.bit_idx      = bit_idx_q;
    assign bus.frame_done   = done_q;
    assign bus.stop_error   = stop_err_q;
    assign bus.start_glitch = glitch_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench: a bit-level UART transmitter drives the line while an expected-event
// schedule, derived from frame timing arithmetic, is compared cycle by cycle with the outputs.
module tb_uart_rx_frame_ctrl;
    localparam int OVS = 8;
    localparam int CW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(.OVS(OVS), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] idx;
        logic       bitv;
        logic       done;
        logic       serr;
        logic       pe;
        logic       pt;
    } ev_t;

    localparam int EV_STROBE = 0;
    localparam int EV_GLITCH = 1;
    localparam int EV_POST   = 2;

    ev_t  evq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
        end
    endtask

    function automatic void push_ev(int at, int kind, logic [3:0] idx, logic bitv,
                                    logic done, logic serr, logic pe, logic pt);
        ev_t ev;
        ev.cyc = at; ev.kind = kind; ev.idx = idx; ev.bitv = bitv;
        ev.done = done; ev.serr = serr; ev.pe = pe; ev.pt = pt;
        evq.push_back(ev);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_cfg_par_en"},   bus.cfg_par_en,   0);
        checkOutput({tag, "_cfg_par_typ"},  bus.cfg_par_typ,  0);
        checkOutput({tag, "_frame_active"}, bus.frame_active, 0);
        checkOutput({tag, "_samp_strobe"},  bus.samp_strobe,  0);
        checkOutput({tag, "_samp_bit"},     bus.samp_bit,     0);
        checkOutput({tag, "_bit_idx"},      bus.bit_idx,      0);
        checkOutput({tag, "_frame_done"},   bus.frame_done,   0);
        checkOutput({tag, "_stop_error"},   bus.stop_error,   0);
        checkOutput({tag, "_start_glitch"}, bus.start_glitch, 0);
    endtask

    // Per-cycle comparison of the pulse outputs against the expected-event schedule.
    ev_t  cur;
    int   cur_kind;
    always @(negedge clk) begin
        if (chk_en) begin
            cur_kind = -1;
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checkOutput("missed_event_cycle", evq[0].cyc, cyc);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                cur = evq.pop_front();
                cur_kind = cur.kind;
            end
            checkOutput("samp_strobe", bus.samp_strobe, (cur_kind == EV_STROBE) ? 1 : 0);
            checkOutput("start_glitch", bus.start_glitch, (cur_kind == EV_GLITCH) ? 1 : 0);
            checkOutput("frame_done", bus.frame_done, (cur_kind == EV_STROBE && cur.done) ? 1 : 0);
            if (cur_kind == EV_STROBE) begin
                checkOutput("bit_idx", bus.bit_idx, cur.idx);
                checkOutput("samp_bit", bus.samp_bit, cur.bitv);
                checkOutput("frame_active", bus.frame_active, 1);
                checkOutput("cfg_par_en", bus.cfg_par_en, cur.pe);
                checkOutput("cfg_par_typ", bus.cfg_par_typ, cur.pt);
                if (cur.done) checkOutput("stop_error", bus.stop_error, cur.serr);
            end
            if (cur_kind == EV_POST) begin
                checkOutput("frame_active_fall", bus.frame_active, 0);
                checkOutput("stop_error_hold", bus.stop_error, cur.serr);
            end
        end
    end

    // Sends one frame starting now; expected strobes follow from the edge cycle E = start + 2.
    task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt,
                                 input logic stop_val, input int glitch_k, input bit stir,
                                 input bit expect_rx, input int abort_k);
        logic bits [0:10];
        int   nbits;
        int   base;
        logic par;
        logic flip;
        par   = pt ? ~(^data) : ^data;
        nbits = pe ? 11 : 10;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = data[k];
        bits[9]  = par;
        bits[10] = 1'b1;
        bits[nbits-1] = stop_val;
        bus.par_en  = pe;
        bus.par_typ = pt;
        base = cyc + 2 + OVS/2 + 2;
        if (expect_rx) begin
            for (int k = 0; k < 8; k++)
                push_ev(base + OVS*(k+1), EV_STROBE, 4'(k), data[k], 1'b0, 1'b0, pe, pt);
            if (pe) push_ev(base + 9*OVS, EV_STROBE, 4'd8, par, 1'b0, 1'b0, pe, pt);
            push_ev(base + (pe ? 10 : 9)*OVS, EV_STROBE, 4'd9, stop_val, 1'b1, ~stop_val, pe, pt);
            push_ev(base + (pe ? 10 : 9)*OVS + 1, EV_POST, 4'd0, 1'b0, 1'b0, ~stop_val, pe, pt);
        end
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < OVS; c++) begin
                if (abort_k >= 0 && i == abort_k + 1 && c == 2) begin
                    evq.delete();
                    bus.rx_in = 1'b1;
                    rst = 1'b0;
                    tick();
                    rst = 1'b1;
                    @(negedge clk);
                    check_reset_outputs("midframe_reset");
                    return;
                end
                flip = (glitch_k >= 0 && i == glitch_k + 1 && c == OVS/2);
                bus.rx_in = bits[i] ^ flip;
                if (stir && i >= 2 && i < nbits - 1) begin
                    bus.en      = 1'($urandom_range(0, 1));
                    bus.par_en  = 1'($urandom_range(0, 1));
                    bus.par_typ = 1'($urandom_range(0, 1));
                end else if (stir && i == nbits - 1) begin
                    bus.en = 1'b1;
                end
                tick();
            end
        end
    endtask

    task automatic send_start_glitch();
        push_ev(cyc + 2 + OVS/2 + 2, EV_GLITCH, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rx_in = 1'b0;
        tick();
        tick();
        idle(OVS + 4);
    endtask

    task automatic hold_low(input int n);
        bus.rx_in = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       pe, pt, sv;
        int         gk;
        bit         st;

        bus.en = 1'b0; bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.par_typ = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        chk_en = 1'b1;
        bus.en = 1'b1;
        idle(4);

        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
        idle(3);
        send_start_glitch();
        applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b1, -1);
        idle(2);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
        idle(2);
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1, -1);
        hold_low(30 - OVS);
        idle(4);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, -1);
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b1, -1);
        idle(1);
        applyStimulus(8'h7E, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b1, -1);
        idle(3);
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 3);
        idle(20);
        bus.en = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, -1);
        idle(3);
        bus.en = 1'b1;
        idle(2);

        for (int n = 0; n < 30; n++) begin
            d  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 5) != 0);
            gk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            st = 1'($urandom_range(0, 1));
            applyStimulus(d, pe, pt, sv, gk, st, 1'b1, -1);
            if (!sv) begin
                hold_low($urandom_range(0, 20));
                idle($urandom_range(2, 6));
            end else begin
                idle($urandom_range(0, 5));
            end
        end

        for (int w = 0; w < 200 && evq.size() > 0; w++) tick();
        checkOutput("drain_pending_events", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
